// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round controller: block handshake, round sequencing and digest strobes.
// Optional abort input enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl #(
    parameter int unsigned ROUNDS = 64
) (
`ifdef SHA256_CTRL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       clk,
    input  logic       reset,
    input  logic       blk_valid,
    input  logic       blk_first,
    input  logic       blk_last,
    output logic       blk_ready,
    output logic       init_round,
    output logic       partial_rounds,
    output logic       init_digest,
    output logic       update_digest,
    output logic       first_block,
    output logic [5:0] round_idx,
    output logic       digest_valid,
    input  logic       digest_ack,
    output logic       busy
);

    localparam int unsigned IDX_W = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        DIGEST,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_d;
    logic             first_q;
    logic             first_d;
    logic             last_q;
    logic             last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of every output, so outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        first_d = first_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    state_d = INIT;
                    first_d = blk_first;
                    last_d  = blk_last;
                end
            end
            INIT: begin
                state_d = ROUND;
            end
            ROUND: begin
                if (round_idx == LAST_IDX) begin
                    state_d = DIGEST;
                end else begin
                    idx_d = round_idx + IDX_W'(1);
                end
            end
            DIGEST: begin
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (digest_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef SHA256_CTRL_ABORT_EN
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            round_idx      <= '0;
            blk_ready      <= 1'b1;
            busy           <= 1'b0;
            init_round     <= 1'b0;
            init_digest    <= 1'b0;
            partial_rounds <= 1'b0;
            update_digest  <= 1'b0;
            digest_valid   <= 1'b0;
            first_block    <= 1'b0;
        end else begin
            first_q        <= first_d;
            last_q         <= last_d;
            round_idx      <= idx_d;
            blk_ready      <= (state_d == IDLE);
            busy           <= (state_d != IDLE);
            init_round     <= (state_d == INIT);
            init_digest    <= (state_d == INIT);
            partial_rounds <= (state_d == ROUND);
            update_digest  <= (state_d == DIGEST);
            digest_valid   <= (state_d == DONE);
            first_block    <= (state_d == INIT) && first_d;
        end
    end

endmodule
